// File: rtl/mem_arbiter_if.sv
// Bundle of the pipeline-side request ports and the memory-side access ports of
// the unified memory arbiter.
//
// Handshake: a requester raises xxReq together with its address (and for the
// data port, dmWe/dmWdata). It then holds xxReq high until it sees the
// one-cycle xxReady pulse. It moves on at the clock edge that closes that
// pulse, and in the following cycle it either presents its next request or
// drops xxReq. The arbiter samples request fields only at the edge that grants
// them, so changes after that edge have no effect on the access in flight.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          ifReq;
    logic [AW-1:0] ifAddr;
    logic [DW-1:0] ifRdata;
    logic          ifReady;
    logic          dmReq;
    logic          dmWe;
    logic [AW-1:0] dmAddr;
    logic [DW-1:0] dmWdata;
    logic [DW-1:0] dmRdata;
    logic          dmReady;
    logic          memEn;
    logic          memWe;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata;
    logic [DW-1:0] memRdata;
    logic          stall;

    modport slave (
        input  ifReq, ifAddr, dmReq, dmWe, dmAddr, dmWdata, memRdata,
        output ifRdata, ifReady, dmRdata, dmReady, memEn, memWe, memAddr,
        output memWdata, stall
    );

    modport master (
        output ifReq, ifAddr, dmReq, dmWe, dmAddr, dmWdata, memRdata,
        input  ifRdata, ifReady, dmRdata, dmReady, memEn, memWe, memAddr,
        input  memWdata, stall
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter for a single-ported unified memory shared by instruction fetch (IF)
// and the data-memory stage (DM). One access at a time: IDLE -> ACCESS for
// LATENCY cycles -> RESP (one-cycle ready pulse) -> IDLE. Ties between IF and
// DM are broken round-robin against the last grant.
module mem_arbiter #(
    parameter int LATENCY = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_arbiter_if.slave       bus,
    output logic [1:0]         dbgState
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    // Counter load value: the last ACCESS cycle is the one where cnt reaches 0.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    // Owner / lastGrant encoding: 0 = IF, 1 = DM.
    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          owner;
    logic          lastGrant;
    logic          latWe;
    logic [AW-1:0] latAddr;
    logic [DW-1:0] latWdata;
    logic [DW-1:0] ifRdataQ;
    logic [DW-1:0] dmRdataQ;
    logic          grantDm;

    // Pick the next owner: a lone requester wins, a tie goes to whoever was not granted last.
    always_comb begin
        grantDm = bus.dmReq;
        if (bus.ifReq && bus.dmReq) begin
            grantDm = ~lastGrant;
        end
    end

    // Access sequencer: grant and latch in IDLE, count down in ACCESS, pulse ready in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            owner     <= 1'b0;
            lastGrant <= 1'b0;
            latWe     <= 1'b0;
            latAddr   <= '0;
            latWdata  <= '0;
            ifRdataQ  <= '0;
            dmRdataQ  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ifReq || bus.dmReq) begin
                        owner     <= grantDm;
                        lastGrant <= grantDm;
                        // Fetches are always reads.
                        latWe     <= grantDm & bus.dmWe;
                        latAddr   <= grantDm ? bus.dmAddr : bus.ifAddr;
                        if (grantDm) begin
                            latWdata <= bus.dmWdata;
                        end
                        cnt       <= CNT_LOAD;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Read data is valid in the last ACCESS cycle; writes leave dmRdata alone.
                        if (!owner) begin
                            ifRdataQ <= bus.memRdata;
                        end else if (!latWe) begin
                            dmRdataQ <= bus.memRdata;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.memEn    = (state == ACCESS);
    assign bus.memWe    = (state == ACCESS) & latWe;
    assign bus.memAddr  = latAddr;
    assign bus.memWdata = latWdata;
    assign bus.ifRdata  = ifRdataQ;
    assign bus.dmRdata  = dmRdataQ;
    assign bus.ifReady  = (state == RESP) & ~owner;
    assign bus.dmReady  = (state == RESP) & owner;
    assign bus.stall    = (bus.ifReq & ~bus.ifReady) | (bus.dmReq & ~bus.dmReady);
    assign dbgState     = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios and randomized traffic on a
// LATENCY=2 instance, checked cycle by cycle against a transaction-level model,
// plus throughput checks on LATENCY=1 and LATENCY=5 instances.
module tb_mem_arbiter;

    localparam int LAT0 = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] st0, st1, st2;

    mem_arbiter_if #(.AW(32), .DW(32)) b0 ();
    mem_arbiter_if #(.AW(32), .DW(32)) b1 ();
    mem_arbiter_if #(.AW(32), .DW(32)) b2 ();

    mem_arbiter #(.LATENCY(LAT0), .AW(32), .DW(32)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0), .dbgState(st0));
    mem_arbiter #(.LATENCY(1),    .AW(32), .DW(32)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1), .dbgState(st1));
    mem_arbiter #(.LATENCY(5),    .AW(32), .DW(32)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2), .dbgState(st2));

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] initVal(input int i);
        return (i == 1) ? 32'h8C01_0000 : 32'h1000_0000 + 32'(i) * 32'h0001_1111;
    endfunction

    // Memory model for u0: 16 words, reloaded on reset, written while memEn & memWe.
    logic [31:0] memArr [16];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) memArr[i] <= initVal(i);
        end else if (b0.memEn && b0.memWe) begin
            memArr[b0.memAddr[5:2]] <= b0.memWdata;
        end
    end
    assign b0.memRdata = memArr[b0.memAddr[5:2]];
    assign b1.memRdata = b1.memAddr ^ 32'h5A5A_0000;
    assign b2.memRdata = b2.memAddr ^ 32'hA5A5_0000;

    // scoreboard counters
    int passCnt = 0;
    int failCnt = 0;
    int totalCnt = 0;

    // transaction-level reference model of u0
    int          cyc;
    int          grantCyc;
    int          doneCyc;
    int          freeAt;
    bit          mLast;
    bit          gWho;
    bit          gWe;
    logic [31:0] gAddr, gWdata, gData;
    logic [31:0] expIf, expDm;
    logic [31:0] refMem [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        chk(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    function automatic logic [31:0] randAddr();
        return ($urandom & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2);
    endfunction

    task automatic rstChecks();
        chkb("rst_memEn", b0.memEn, 1'b0);
        chkb("rst_memWe", b0.memWe, 1'b0);
        chkb("rst_ifReady", b0.ifReady, 1'b0);
        chkb("rst_dmReady", b0.dmReady, 1'b0);
        chk("rst_ifRdata", b0.ifRdata, 32'h0);
        chk("rst_dmRdata", b0.dmRdata, 32'h0);
        chk("rst_memAddr", b0.memAddr, 32'h0);
        chk("rst_memWdata", b0.memWdata, 32'h0);
        chk("rst_state", {30'b0, st0}, 32'h0);
        chkb("rst_lat1_en", b1.memEn, 1'b0);
        chkb("rst_lat5_en", b2.memEn, 1'b0);
    endtask

    task automatic applyReset(input int n);
        rst_n = 1'b0;
        #1;
        rstChecks();
        grantCyc = -100;
        doneCyc  = -100;
        freeAt   = 0;
        mLast    = 1'b0;
        gWho     = 1'b0;
        gWe      = 1'b0;
        expIf    = 32'h0;
        expDm    = 32'h0;
        for (int i = 0; i < 16; i++) refMem[i] = initVal(i);
        repeat (n) begin
            @(posedge clk);
            #1;
            rstChecks();
        end
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // Decide, from the requests present before the edge, what the arbiter grants at it.
    task automatic modelEdge();
        bit who;
        if (cyc >= freeAt && (b0.ifReq || b0.dmReq)) begin
            who      = (b0.ifReq && b0.dmReq) ? !mLast : b0.dmReq;
            mLast    = who;
            gWho     = who;
            grantCyc = cyc;
            doneCyc  = cyc + LAT0 + 1;
            freeAt   = cyc + LAT0 + 2;
            gWe      = who && b0.dmWe;
            gAddr    = who ? b0.dmAddr : b0.ifAddr;
            gWdata   = b0.dmWdata;
            if (gWe) refMem[gAddr[5:2]] = gWdata;
            else     gData = refMem[gAddr[5:2]];
        end
    endtask

    task automatic cycleEnd();
        modelEdge();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == doneCyc && !gWe) begin
            if (gWho) expDm = gData;
            else      expIf = gData;
        end
    endtask

    task automatic checkCycle();
        bit inAcc, eIf, eDm;
        inAcc = (cyc > grantCyc) && (cyc <= grantCyc + LAT0);
        eIf   = (cyc == doneCyc) && !gWho;
        eDm   = (cyc == doneCyc) && gWho;
        chkb("memEn", b0.memEn, inAcc);
        chkb("memWe", b0.memWe, inAcc && gWe);
        if (inAcc) chk("memAddr", b0.memAddr, gAddr);
        if (inAcc && gWe) chk("memWdata", b0.memWdata, gWdata);
        chkb("ifReady", b0.ifReady, eIf);
        chkb("dmReady", b0.dmReady, eDm);
        chk("ifRdata", b0.ifRdata, expIf);
        chk("dmRdata", b0.dmRdata, expDm);
        chkb("stall", b0.stall, (b0.ifReq && !eIf) || (b0.dmReq && !eDm));
    endtask

    task automatic run(input int n);
        repeat (n) begin
            #1;
            checkCycle();
            cycleEnd();
        end
    endtask

    // stimulus / driver
    int s, prev1, prev2, n1, n2;
    bit who1, who2;
    bit ifDoneLast, ifFlight, dmDoneLast, dmFlight;

    initial begin
        rst_n = 1'b0;
        b0.ifReq = 0; b0.ifAddr = 0; b0.dmReq = 0; b0.dmWe = 0; b0.dmAddr = 0; b0.dmWdata = 0;
        b1.ifReq = 0; b1.ifAddr = 32'h100; b1.dmReq = 0; b1.dmWe = 0; b1.dmAddr = 32'h200; b1.dmWdata = 0;
        b2.ifReq = 0; b2.ifAddr = 32'h300; b2.dmReq = 0; b2.dmWe = 0; b2.dmAddr = 32'h400; b2.dmWdata = 0;
        cyc = 0;
        applyReset(2);

        // Single fetch after reset.
        b0.ifReq = 1; b0.ifAddr = 32'h4;
        #1;
        chkb("t1_stall_c0", b0.stall, 1'b1);
        run(1);
        #1;
        chkb("t1_memEn_c1", b0.memEn, 1'b1);
        run(2);
        #1;
        chkb("t1_ifReady_c3", b0.ifReady, 1'b1);
        chk("t1_ifRdata_c3", b0.ifRdata, 32'h8C01_0000);
        chkb("t1_stall_c3", b0.stall, 1'b0);
        run(1);
        b0.ifReq = 0;
        run(2);

        // Ties after reset: DM, then IF, then DM again.
        applyReset(2);
        b0.ifReq = 1; b0.ifAddr = 32'h8; b0.dmReq = 1; b0.dmWe = 0; b0.dmAddr = 32'h10;
        run(3);
        #1;
        chkb("t2_dm_first", b0.dmReady, 1'b1);
        chkb("t2_if_not_first", b0.ifReady, 1'b0);
        chk("t2_dmRdata", b0.dmRdata, 32'h1004_4444);
        run(4);
        #1;
        chkb("t2_if_second", b0.ifReady, 1'b1);
        chk("t2_ifRdata", b0.ifRdata, 32'h1002_2222);
        run(4);
        #1;
        chkb("t2_dm_third", b0.dmReady, 1'b1);
        run(1);

        // DM write, with dmAddr changed mid-access.
        b0.ifReq = 0; b0.dmReq = 1; b0.dmWe = 1; b0.dmAddr = 32'h20; b0.dmWdata = 32'hDEAD_BEEF;
        run(1);
        b0.dmAddr = 32'h40;
        #1;
        chkb("t3_memWe_a1", b0.memWe, 1'b1);
        chk("t3_memAddr_a1", b0.memAddr, 32'h20);
        chk("t3_memWdata_a1", b0.memWdata, 32'hDEAD_BEEF);
        run(1);
        #1;
        chkb("t3_memWe_a2", b0.memWe, 1'b1);
        chk("t3_memAddr_a2", b0.memAddr, 32'h20);
        run(1);
        #1;
        chkb("t3_dmReady", b0.dmReady, 1'b1);
        chk("t3_dmRdata_kept", b0.dmRdata, 32'h1004_4444);
        chkb("t3_memEn_resp", b0.memEn, 1'b0);
        run(1);
        b0.dmReq = 0; b0.dmWe = 0;

        // Reset during the second ACCESS cycle of a fetch; the held request restarts.
        b0.ifReq = 1; b0.ifAddr = 32'h4;
        run(2);
        #1;
        chkb("t4_memEn_before_rst", b0.memEn, 1'b1);
        applyReset(2);
        run(1);
        #1;
        chkb("t4_restart_memEn", b0.memEn, 1'b1);
        run(2);
        #1;
        chkb("t4_restart_ready", b0.ifReady, 1'b1);
        chk("t4_restart_rdata", b0.ifRdata, 32'h8C01_0000);
        run(1);
        b0.ifReq = 0;
        run(1);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            ifDoneLast = (doneCyc == cyc - 1) && !gWho;
            ifFlight   = (cyc > grantCyc) && (cyc <= doneCyc) && !gWho;
            dmDoneLast = (doneCyc == cyc - 1) && gWho;
            dmFlight   = (cyc > grantCyc) && (cyc <= doneCyc) && gWho;
            if (ifDoneLast || b0.ifReq == 1'b0) begin
                b0.ifReq  = ($urandom_range(0, 2) != 0);
                b0.ifAddr = randAddr();
            end else if (ifFlight) begin
                b0.ifAddr = randAddr();
                if ($urandom_range(0, 7) == 0) b0.ifReq = 0;
            end
            if (dmDoneLast || b0.dmReq == 1'b0) begin
                b0.dmReq   = ($urandom_range(0, 2) != 0);
                b0.dmWe    = 1'($urandom_range(0, 1));
                b0.dmAddr  = randAddr();
                b0.dmWdata = $urandom;
            end else if (dmFlight) begin
                b0.dmWe    = 1'($urandom_range(0, 1));
                b0.dmAddr  = randAddr();
                b0.dmWdata = $urandom;
                if ($urandom_range(0, 7) == 0) b0.dmReq = 0;
            end
            run(1);
        end
        b0.ifReq = 0; b0.dmReq = 0;

        // Continuous tied requests on the LATENCY=1 and LATENCY=5 instances.
        b1.ifReq = 1; b1.dmReq = 1;
        b2.ifReq = 1; b2.dmReq = 1;
        s = cyc; prev1 = -1; prev2 = -1; n1 = 0; n2 = 0; who1 = 0; who2 = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            chkb("lat1_excl", b1.ifReady & b1.dmReady, 1'b0);
            chkb("lat5_excl", b2.ifReady & b2.dmReady, 1'b0);
            if (b1.ifReady || b1.dmReady) begin
                if (prev1 < 0) begin
                    chk("lat1_first_cycle", cyc - s, 2);
                    chkb("lat1_first_dm", b1.dmReady, 1'b1);
                end else begin
                    chk("lat1_period", cyc - prev1, 3);
                    chkb("lat1_alternate", b1.dmReady, !who1);
                end
                who1 = b1.dmReady; prev1 = cyc; n1++;
            end
            if (b2.ifReady || b2.dmReady) begin
                if (prev2 < 0) begin
                    chk("lat5_first_cycle", cyc - s, 6);
                    chkb("lat5_first_dm", b2.dmReady, 1'b1);
                end else begin
                    chk("lat5_period", cyc - prev2, 7);
                    chkb("lat5_alternate", b2.dmReady, !who2);
                end
                who2 = b2.dmReady; prev2 = cyc; n2++;
            end
            checkCycle();
            cycleEnd();
        end
        chk("lat1_pulses", n1, 13);
        chk("lat5_pulses", n2, 5);

        // final report
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences a single-ported unified memory shared by the pipeline's instruction-fetch port (IF) and data-memory port (MEM stage).
- Grants one requester at a time, drives the memory for a fixed access latency, and returns read data with a one-cycle ready pulse.
- Provides a global stall so the pipeline freezes while any request is outstanding.
- Sits between the pipeline stages and the memory model, in place of separate instruction and data memories.

Parameters:
- LATENCY, 2, memory cycles per access; legal range 1..15; memRdata is valid in the last ACCESS cycle.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ifReq  in  1  instruction fetch request; held high until ifReady
- ifAddr  in  AW  fetch address
- ifRdata  out  DW  fetched instruction; registered; held until the next IF completion
- ifReady  out  1  one-cycle completion pulse for IF
- dmReq  in  1  data request, read or write; held high until dmReady
- dmWe  in  1  1 = write, 0 = read
- dmAddr  in  AW  data address
- dmWdata  in  DW  store data
- dmRdata  out  DW  load data; registered; held until the next DM read completion
- dmReady  out  1  one-cycle completion pulse for DM
- memEn  out  1  memory access enable
- memWe  out  1  memory write enable
- memAddr  out  AW  memory address
- memWdata  out  DW  memory write data
- memRdata  in  DW  memory read data
- stall  out  1  (ifReq & ~ifReady) | (dmReq & ~dmReady); combinational

Behaviour:
- Reset (async, rst_n=0): state IDLE, cnt 0, owner IF, lastGrant IF. ifRdata and dmRdata are 0. ifReady, dmReady, memEn and memWe are 0. Latched memAddr and memWdata are 0.
- Reset mid-access aborts the access: memEn/memWe drop immediately, no ready pulse is issued, and rdata registers clear.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, no request: stays in IDLE; memEn=0.
- IDLE, request present: at the rising edge, pick the owner, latch addr/we/wdata, load cnt=LATENCY-1, go to ACCESS.
- IF requests are always treated as reads; memWe=0 for IF.
- Arbitration when only one request is present: grant it.
- Arbitration when both are present: round-robin; grant the requester other than lastGrant. lastGrant updates on each grant. After reset the first tie goes to DM.
- ACCESS: memEn=1; memWe = latched we; memAddr/memWdata = latched values, stable for the whole ACCESS.
  - cnt>0: decrement cnt each edge.
  - cnt==0: at the edge, capture memRdata into the owner's rdata register (reads only; writes leave dmRdata unchanged), go to RESP.
- RESP: owner's ready=1 for exactly this cycle; memEn=0; next edge goes to IDLE.
- Timing: request sampled at edge E; ACCESS occupies LATENCY cycles; ready is high in cycle E+LATENCY+1. Back-to-back throughput is one access per LATENCY+2 cycles.
- Requester rule: the requester observes ready, advances at the edge closing RESP, and presents its next request (or drops req) in the following cycle.
- Input changes during ACCESS/RESP (addr, we, wdata, or req dropped) are ignored. The access completes and ready still pulses.
- Both requests present in RESP: no effect in RESP; they are arbitrated in the following IDLE cycle.
- ready is never asserted for the non-owner; ifReady and dmReady are never high together.
- Address is passed through unchanged; no alignment checks.

Test Plan:
- Reset with ifReq=1, ifAddr=0x4, memRdata=0x8C010000, LATENCY=2, edge at cycle 0 → memEn=1 in cycles 1–2; ifReady=1 only in cycle 3; ifRdata=0x8C010000 from cycle 3; stall=1 in cycles 0–2, 0 in cycle 3.
- ifReq and dmReq raised together after reset (dmWe=0, dmAddr=0x10) → DM granted first (dmReady at cycle 3), IF granted next (ifReady at cycle 7); a third tie goes to DM.
- DM write (dmWe=1, dmAddr=0x20, dmWdata=0xDEADBEEF) → memWe=1 with stable addr/data for 2 cycles; dmReady pulses once; dmRdata keeps its prior value.
- Assert rst_n=0 during the second ACCESS cycle → memEn falls immediately; no ready pulse; after release, the held request restarts a full LATENCY access.
- LATENCY=1 and LATENCY=5 builds with continuous alternating requests → ready period 3 and 7 cycles respectively; no cycle with both readies high.
- Change dmAddr from 0x20 to 0x40 mid-ACCESS → memAddr stays 0x20 for the whole access.
